// File: rtl/detection_collector_if.sv
// Signal bundle between the face-detector result outputs, the detection
// collector and the host readout stream.
interface detection_collector_if #(
    parameter int COORD_WIDTH = 8,
    parameter int MAX_DET     = 8
);
    localparam int CNT_W = $clog2(MAX_DET + 1);

    logic                   start;
    logic                   det_valid;
    logic [COORD_WIDTH-1:0] det_x;
    logic [COORD_WIDTH-1:0] det_y;
    logic [COORD_WIDTH-1:0] det_scale;
    logic                   frame_done;
    logic                   out_valid;
    logic                   out_ready;
    logic [COORD_WIDTH-1:0] out_x;
    logic [COORD_WIDTH-1:0] out_y;
    logic [COORD_WIDTH-1:0] out_scale;
    logic [7:0]             out_hits;
    logic                   out_last;
    logic [CNT_W-1:0]       num_dets;
    logic                   overflow;
    logic                   busy;
    logic                   collect_done;

    modport master (
        output start, det_valid, det_x, det_y, det_scale, frame_done, out_ready,
        input  out_valid, out_x, out_y, out_scale, out_hits, out_last,
               num_dets, overflow, busy, collect_done
    );

    modport slave (
        input  start, det_valid, det_x, det_y, det_scale, frame_done, out_ready,
        output out_valid, out_x, out_y, out_scale, out_hits, out_last,
               num_dets, overflow, busy, collect_done
    );
endinterface

// File: rtl/detection_collector.sv
// Collects one frame of face detections, merges same-scale near-duplicates
// into hit-counted entries, then drains the merged list over valid/ready.
module detection_collector #(
    parameter int MAX_DET     = 8,
    parameter int MERGE_DIST  = 4,
    parameter int COORD_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    detection_collector_if.slave bus
);
    localparam int CNT_W  = $clog2(MAX_DET + 1);
    localparam int IDX_W  = (MAX_DET > 1) ? $clog2(MAX_DET) : 1;
    localparam int DIFF_W = COORD_WIDTH + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    logic [1:0]             r_state;
    logic [COORD_WIDTH-1:0] r_x     [MAX_DET];
    logic [COORD_WIDTH-1:0] r_y     [MAX_DET];
    logic [COORD_WIDTH-1:0] r_s     [MAX_DET];
    logic [7:0]             r_hits  [MAX_DET];
    logic [CNT_W-1:0]       r_num;
    logic [CNT_W-1:0]       r_idx;
    logic                   r_over;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic [COORD_WIDTH-1:0] r_out_x;
    logic [COORD_WIDTH-1:0] r_out_y;
    logic [COORD_WIDTH-1:0] r_out_s;
    logic [7:0]             r_out_hits;
    logic                   r_collect_done;

    logic [DIFF_W-1:0]      w_dx [MAX_DET];
    logic [DIFF_W-1:0]      w_dy [MAX_DET];
    logic [MAX_DET-1:0]     w_match;
    logic                   w_hit;
    logic [IDX_W-1:0]       w_hit_idx;
    logic                   w_full;

    // Parallel compare of the incoming detection against every stored entry;
    // entries are registers, so the previous cycle's write is already visible.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_match   = '0;
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < MAX_DET; i++) begin
            w_dx[i] = (bus.det_x >= r_x[i]) ? DIFF_W'(bus.det_x) - DIFF_W'(r_x[i])
                                            : DIFF_W'(r_x[i]) - DIFF_W'(bus.det_x);
            w_dy[i] = (bus.det_y >= r_y[i]) ? DIFF_W'(bus.det_y) - DIFF_W'(r_y[i])
                                            : DIFF_W'(r_y[i]) - DIFF_W'(bus.det_y);
            w_match[i] = (CNT_W'(i) < r_num) && (bus.det_scale == r_s[i]) &&
                         (w_dx[i] <= DIFF_W'(MERGE_DIST)) && (w_dy[i] <= DIFF_W'(MERGE_DIST));
        end
        for (int i = MAX_DET - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    assign w_full = (r_num == CNT_W'(MAX_DET));

    // NOTE: sequential state uses non-blocking assignments only, so every read
    // in this block sees the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            // NOTE: the entry buffer is a handful of flops, so it is reset
            // along with the control state rather than left undefined.
            for (int i = 0; i < MAX_DET; i++) begin
                r_x[i]    <= '0;
                r_y[i]    <= '0;
                r_s[i]    <= '0;
                r_hits[i] <= '0;
            end
            r_num          <= '0;
            r_idx          <= '0;
            r_over         <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_out_x        <= '0;
            r_out_y        <= '0;
            r_out_s        <= '0;
            r_out_hits     <= '0;
            r_collect_done <= 1'b0;
        end else begin
            r_collect_done <= 1'b0;
            if (bus.start) begin
                r_state     <= S_COLLECT;
                r_num       <= '0;
                r_idx       <= '0;
                r_over      <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                case (r_state)
                    S_COLLECT: begin
                        if (bus.det_valid) begin
                            if (w_hit) begin
                                if (r_hits[w_hit_idx] != 8'hFF)
                                    r_hits[w_hit_idx] <= r_hits[w_hit_idx] + 8'd1;
                            end else if (!w_full) begin
                                r_x[IDX_W'(r_num)]    <= bus.det_x;
                                r_y[IDX_W'(r_num)]    <= bus.det_y;
                                r_s[IDX_W'(r_num)]    <= bus.det_scale;
                                r_hits[IDX_W'(r_num)] <= 8'd1;
                                r_num                 <= r_num + 1'b1;
                            end else begin
                                r_over <= 1'b1;
                            end
                        end
                        if (bus.frame_done) begin
                            r_state <= S_DRAIN;
                            r_idx   <= '0;
                        end
                    end
                    S_DRAIN: begin
                        // Output register refills whenever it is empty or being consumed.
                        if (!r_out_valid || bus.out_ready) begin
                            if (r_out_valid && r_out_last) begin
                                r_out_valid    <= 1'b0;
                                r_out_last     <= 1'b0;
                                r_collect_done <= 1'b1;
                                r_state        <= S_IDLE;
                            end else if (r_idx < r_num) begin
                                r_out_valid <= 1'b1;
                                r_out_last  <= (r_idx == r_num - 1'b1);
                                r_out_x     <= r_x[IDX_W'(r_idx)];
                                r_out_y     <= r_y[IDX_W'(r_idx)];
                                r_out_s     <= r_s[IDX_W'(r_idx)];
                                r_out_hits  <= r_hits[IDX_W'(r_idx)];
                                r_idx       <= r_idx + 1'b1;
                            end else begin
                                r_out_valid    <= 1'b0;
                                r_collect_done <= 1'b1;
                                r_state        <= S_IDLE;
                            end
                        end
                    end
                    S_IDLE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.out_last     = r_out_last;
    assign bus.out_x        = r_out_x;
    assign bus.out_y        = r_out_y;
    assign bus.out_scale    = r_out_s;
    assign bus.out_hits     = r_out_hits;
    assign bus.num_dets     = r_num;
    assign bus.overflow     = r_over;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.collect_done = r_collect_done;

endmodule

// File: tb/tb_detection_collector.sv
// Scoreboard bench for detection_collector: a list model builds the expected
// merged entries, which are compared against the drained stream.
module tb_detection_collector;
    localparam int CW    = 8;
    localparam int MD    = 8;
    localparam int MDIST = 4;

    typedef struct {
        int x;
        int y;
        int s;
        int hits;
        bit last;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    detection_collector_if #(.COORD_WIDTH(CW), .MAX_DET(MD)) bus ();

    detection_collector #(.MAX_DET(MD), .MERGE_DIST(MDIST), .COORD_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t m_list[$];
    ent_t exp_q[$];
    bit   m_over;
    int   tests = 0;
    int   fails = 0;

    function automatic int absd(int a, int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_det(input int x, input int y, input int s);
        for (int i = 0; i < m_list.size(); i++) begin
            if (m_list[i].s == s && absd(x, m_list[i].x) <= MDIST && absd(y, m_list[i].y) <= MDIST) begin
                if (m_list[i].hits < 255) m_list[i].hits++;
                return;
            end
        end
        if (m_list.size() < MD) m_list.push_back('{x: x, y: y, s: s, hits: 1, last: 1'b0});
        else m_over = 1'b1;
    endtask

    task automatic push_expected();
        for (int i = 0; i < m_list.size(); i++) begin
            ent_t e;
            e      = m_list[i];
            e.last = (i == m_list.size() - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        m_list.delete();
        exp_q.delete();
        m_over = 1'b0;
    endtask

    task automatic send_det(input int x, input int y, input int s, input bit fd);
        bus.det_valid  = 1'b1;
        bus.det_x      = CW'(x);
        bus.det_y      = CW'(y);
        bus.det_scale  = CW'(s);
        bus.frame_done = fd;
        model_det(x, y, s);
        if (fd) push_expected();
        @(negedge clk);
        bus.det_valid  = 1'b0;
        bus.frame_done = 1'b0;
    endtask

    task automatic frame_end();
        bus.frame_done = 1'b1;
        push_expected();
        @(negedge clk);
        bus.frame_done = 1'b0;
    endtask

    // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0 per valid cycle
    task automatic drain(input int mode, output int done_cyc);
        int   cyc = 0;
        int   n_done = 0;
        int   p = 0;
        bit   held = 1'b0;
        bit   timed_out = 1'b1;
        bit   rdy;
        ent_t e;
        logic [CW-1:0] hx, hy, hs;
        logic [7:0]    hh;
        logic          hl;
        done_cyc = -1;
        bus.out_ready = 1'b0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.collect_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end else if (n_done > 0) begin
                timed_out = 1'b0;
                break;
            end
            if (bus.out_valid) begin
                if (held) begin
                    tests++;
                    if ({bus.out_x, bus.out_y, bus.out_scale, bus.out_hits, bus.out_last} !== {hx, hy, hs, hh, hl}) begin
                        fails++;
                        $display("FAIL hold_stable: got x=%0d y=%0d s=%0d h=%0d last=%0b, expected x=%0d y=%0d s=%0d h=%0d last=%0b",
                                 bus.out_x, bus.out_y, bus.out_scale, bus.out_hits, bus.out_last, hx, hy, hs, hh, hl);
                    end
                end
                rdy = (mode == 0) || (p % 3 == 0);
                p++;
                bus.out_ready = rdy;
                if (rdy) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL extra_entry: got x=%0d y=%0d s=%0d h=%0d, expected no entry",
                                 bus.out_x, bus.out_y, bus.out_scale, bus.out_hits);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(bus.out_x) != e.x || int'(bus.out_y) != e.y || int'(bus.out_scale) != e.s ||
                            int'(bus.out_hits) != e.hits || bus.out_last !== e.last) begin
                            fails++;
                            $display("FAIL entry: got x=%0d y=%0d s=%0d h=%0d last=%0b, expected x=%0d y=%0d s=%0d h=%0d last=%0b",
                                     bus.out_x, bus.out_y, bus.out_scale, bus.out_hits, bus.out_last,
                                     e.x, e.y, e.s, e.hits, e.last);
                        end
                    end
                end
                held = !rdy;
                hx = bus.out_x; hy = bus.out_y; hs = bus.out_scale; hh = bus.out_hits; hl = bus.out_last;
            end else begin
                bus.out_ready = (mode == 0);
                held = 1'b0;
            end
        end
        bus.out_ready = 1'b0;
        tests++;
        if (timed_out) begin
            fails++;
            $display("FAIL drain_timeout: got no completion in %0d cycles, expected collect_done", cyc);
        end
        tests++;
        if (n_done != 1) begin
            fails++;
            $display("FAIL collect_done_pulses: got %0d, expected 1", n_done);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_entries: got %0d undrained, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.det_valid = 1'b0; bus.frame_done = 1'b0; bus.out_ready = 1'b0;
        bus.det_x = '0; bus.det_y = '0; bus.det_scale = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.out_valid, bus.out_last, bus.out_x, bus.out_y, bus.out_scale, bus.out_hits,
             bus.num_dets, bus.overflow, bus.busy, bus.collect_done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b x=%0d hits=%0d num=%0d busy=%b, expected all 0",
                     bus.out_valid, bus.out_x, bus.out_hits, bus.num_dets, bus.busy);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got busy=%b, expected 0", bus.busy);
        end
    endtask

    task automatic test_basic_merge();
        int dc;
        do_start();
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_collect: got %b, expected 1", bus.busy);
        end
        send_det(10, 10, 1, 1'b0);
        send_det(12, 13, 1, 1'b0);
        send_det(40, 40, 1, 1'b0);
        frame_end();
        tests++;
        if (int'(bus.num_dets) != m_list.size()) begin
            fails++;
            $display("FAIL basic_num_dets: got %0d, expected %0d", bus.num_dets, m_list.size());
        end
        drain(0, dc);
        tests++;
        if (bus.busy !== 1'b0 || int'(bus.num_dets) != 2) begin
            fails++;
            $display("FAIL basic_idle: got busy=%b num=%0d, expected busy=0 num=2", bus.busy, bus.num_dets);
        end
        bus.det_valid = 1'b1; bus.det_x = 8'd90; bus.det_y = 8'd90; bus.det_scale = 8'd9;
        @(negedge clk);
        bus.det_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (int'(bus.num_dets) != 2) begin
            fails++;
            $display("FAIL idle_det_ignored: got num=%0d, expected 2", bus.num_dets);
        end
    endtask

    task automatic test_scale_and_distance();
        int dc;
        do_start();
        send_det(10, 10, 1, 1'b0);
        send_det(10, 10, 2, 1'b0);
        send_det(6, 14, 1, 1'b0);
        send_det(255, 10, 2, 1'b0);
        send_det(15, 10, 1, 1'b1);
        tests++;
        if (int'(bus.num_dets) != 4) begin
            fails++;
            $display("FAIL scale_num_dets: got %0d, expected 4", bus.num_dets);
        end
        drain(0, dc);
    endtask

    task automatic test_overflow();
        int dc;
        do_start();
        for (int i = 0; i < 10; i++) send_det(i * 20, 0, 3, 1'b0);
        send_det(2, 1, 3, 1'b0);
        frame_end();
        tests++;
        if (int'(bus.num_dets) != MD || bus.overflow !== m_over || !m_over) begin
            fails++;
            $display("FAIL overflow_state: got num=%0d ovf=%b, expected num=%0d ovf=1", bus.num_dets, bus.overflow, MD);
        end
        drain(0, dc);
        tests++;
        if (bus.overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky: got %b, expected 1", bus.overflow);
        end
    endtask

    task automatic test_back_pressure();
        int dc;
        do_start();
        send_det(100, 100, 0, 1'b0);
        send_det(5, 200, 0, 1'b0);
        send_det(100, 100, 5, 1'b0);
        send_det(103, 97, 5, 1'b0);
        frame_end();
        drain(1, dc);
    endtask

    task automatic test_saturation();
        int dc;
        do_start();
        for (int i = 0; i < 300; i++) send_det(50 + (i % 3), 50, 7, 1'b0);
        frame_end();
        drain(0, dc);
    endtask

    task automatic test_empty_frame();
        int dc;
        do_start();
        frame_end();
        drain(0, dc);
        tests++;
        if (dc != 1) begin
            fails++;
            $display("FAIL empty_done_latency: got cycle %0d, expected 1", dc);
        end
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL empty_idle: got busy=%b, expected 0", bus.busy);
        end
    endtask

    task automatic test_rst_mid_drain();
        bit seen = 1'b0;
        do_start();
        send_det(20, 20, 1, 1'b0);
        send_det(60, 60, 1, 1'b0);
        frame_end();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL rst_drain_valid: got out_valid=0, expected 1 within 10 cycles");
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus.out_valid, bus.out_last, bus.out_x, bus.out_y, bus.out_scale, bus.out_hits,
             bus.num_dets, bus.overflow, bus.busy, bus.collect_done} !== '0) begin
            fails++;
            $display("FAIL async_reset: got valid=%b x=%0d hits=%0d num=%0d busy=%b, expected all 0",
                     bus.out_valid, bus.out_x, bus.out_hits, bus.num_dets, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_start_mid_drain();
        bit seen = 1'b0;
        int dc;
        do_start();
        for (int i = 0; i < 9; i++) send_det(i * 25, 30, 2, 1'b0);
        frame_end();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        tests++;
        if (!seen || bus.overflow !== 1'b1) begin
            fails++;
            $display("FAIL start_drain_pre: got valid=%b ovf=%b, expected valid=1 ovf=1", bus.out_valid, bus.overflow);
        end
        do_start();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.num_dets !== '0 || bus.overflow !== 1'b0 ||
            bus.busy !== 1'b1 || bus.collect_done !== 1'b0) begin
            fails++;
            $display("FAIL start_abort: got valid=%b num=%0d ovf=%b busy=%b done=%b, expected 0 0 0 1 0",
                     bus.out_valid, bus.num_dets, bus.overflow, bus.busy, bus.collect_done);
        end
        send_det(70, 70, 4, 1'b1);
        drain(0, dc);
    endtask

    initial begin
        test_reset();
        test_basic_merge();
        test_scale_and_distance();
        test_overflow();
        test_back_pressure();
        test_saturation();
        test_empty_frame();
        test_rst_mid_drain();
        test_start_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
